// File: rtl/bus_decode_arbiter.sv
// Registered address decoder and single-master router: one master port fanned out
// to NUM_SLAVES memory-mapped slaves, with timeout, error responses and an error counter.
module bus_decode_arbiter #(
    parameter int unsigned NUM_SLAVES = 5,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h0000_8020, 32'h0000_8010, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_LIMIT =
        {32'h0000_802F, 32'h0000_801F, 32'h0000_800F, 32'h0000_6FFF, 32'h0000_3FFF},
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic                         m_we,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_we,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         busy,
    output logic [7:0]                   err_cnt
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [NUM_SLAVES-1:0]   r_sel;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_we;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W/8-1:0]     r_wstrb;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;
    logic [7:0]              r_err_cnt;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_hit_idx;
    logic [NUM_SLAVES-1:0]   w_hit_onehot;
    logic                    w_s_ready;
    logic [DATA_W-1:0]       w_s_rdata;
    logic                    w_timeout;

    // First matching window in index order wins, so overlaps resolve to the lowest slave.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_hit_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit &&
                (m_addr >= SLAVE_BASE[i*ADDR_W +: ADDR_W]) &&
                (m_addr <= SLAVE_LIMIT[i*ADDR_W +: ADDR_W])) begin
                w_hit           = 1'b1;
                w_hit_idx       = IDX_W'(i);
                w_hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_s_ready = 1'b0;
        w_s_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_s_ready = s_ready[i];
                w_s_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    w_next = w_hit ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (w_s_ready || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_valid) begin
                        r_addr  <= m_addr;
                        r_we    <= m_we;
                        r_wdata <= m_wdata;
                        r_wstrb <= m_wstrb;
                        r_idx   <= w_hit_idx;
                        r_cnt   <= '0;
                        r_sel   <= w_hit_onehot;
                        r_rdata <= '0;
                        r_err   <= ~w_hit;
                    end
                end
                ST_ACCESS: begin
                    // Slave ready is checked before the timeout so a last-cycle ready still succeeds.
                    if (w_s_ready) begin
                        r_sel   <= '0;
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_s_rdata;
                    end else if (w_timeout) begin
                        r_sel   <= '0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    if (r_err && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: begin
                    r_sel <= '0;
                end
            endcase
        end
    end

    assign m_ready = (r_state == ST_RESP);
    assign busy    = (r_state != ST_IDLE);
    assign m_rdata = r_rdata;
    assign m_err   = r_err;
    assign s_sel   = r_sel;
    assign s_addr  = r_addr;
    assign s_we    = r_we;
    assign s_wdata = r_wdata;
    assign s_wstrb = r_wstrb;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_bus_decode_arbiter.sv
// Scoreboard bench: driver pushes expected responses from a window/latency model,
// a monitor pops and compares whenever m_ready is presented.
module tb_bus_decode_arbiter;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic         m_err;
    logic [4:0]   s_sel;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [4:0]   s_ready = '0;
    logic [159:0] s_rdata;
    logic         busy;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    bus_decode_arbiter #(
        .NUM_SLAVES (5),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLAVE_BASE ({32'h0000_8020, 32'h0000_8010, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000}),
        .SLAVE_LIMIT({32'h0000_802F, 32'h0000_801F, 32'h0000_800F, 32'h0000_6FFF, 32'h0000_3FFF}),
        .TIMEOUT    (TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    logic [31:0] base_a  [5] = '{32'h0000, 32'h4000, 32'h8000, 32'h8010, 32'h8020};
    logic [31:0] limit_a [5] = '{32'h3FFF, 32'h6FFF, 32'h800F, 32'h801F, 32'h802F};

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [4:0]  sel;
        int          sel_cycles;
        logic [31:0] rdata;
        logic        err;
        longint      exp_edge;
        int          errcnt;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     model_errcnt = 0;
    bit     rst_test = 0;

    int          sl_idx = 0;
    int          sl_k = 0;
    logic [31:0] sl_rd [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    int          sl_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        s_rdata = '0;
        for (int i = 0; i < 5; i++) s_rdata[i*32 +: 32] = sl_rd[i];
    end

    // Slave model: target raises ready on its k-th selected cycle; other bits carry noise.
    always @(negedge clk) begin
        logic [4:0] r;
        if (s_sel != 5'b0) sl_cnt = sl_cnt + 1;
        else sl_cnt = 0;
        r = 5'($urandom);
        r[sl_idx] = 1'b0;
        if (s_sel != 5'b0 && sl_k != 0 && sl_cnt == sl_k) r[sl_idx] = 1'b1;
        s_ready = r;
    end

    int sel_seen = 0;
    bit pend = 0;
    int pend_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sel_seen = 0;
            pend = 0;
        end else begin
            if (pend) begin
                checks++;
                if (err_cnt !== 8'(pend_cnt) || m_rdata !== 32'h0 || m_err !== 1'b0 || m_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL post_resp: err_cnt=%0d rdata=%h err=%b ready=%b, required err_cnt=%0d rdata=0 err=0 ready=0",
                             err_cnt, m_rdata, m_err, m_ready, pend_cnt);
                end
                pend = 0;
            end
            if (s_sel != 5'b0) begin
                if (q.size() == 0) begin
                    if (!rst_test) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_sel: s_sel=%b with no request outstanding, required 00000", s_sel);
                    end
                end else begin
                    sel_seen++;
                    checks++;
                    if (s_sel !== q[0].sel || s_addr !== q[0].addr || s_we !== q[0].we ||
                        s_wdata !== q[0].wdata || s_wstrb !== q[0].wstrb) begin
                        errors++;
                        $display("FAIL access_fields: sel=%b addr=%h we=%b wdata=%h wstrb=%b, required sel=%b addr=%h we=%b wdata=%h wstrb=%b",
                                 s_sel, s_addr, s_we, s_wdata, s_wstrb,
                                 q[0].sel, q[0].addr, q[0].we, q[0].wdata, q[0].wstrb);
                    end
                end
            end
            if (m_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: m_ready=1 at cycle %0d, required no response", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc + 1 != e.exp_edge || m_rdata !== e.rdata || m_err !== e.err ||
                        sel_seen != e.sel_cycles) begin
                        errors++;
                        $display("FAIL response addr=%h: edge=%0d rdata=%h err=%b sel_cycles=%0d, required edge=%0d rdata=%h err=%b sel_cycles=%0d",
                                 e.addr, cyc + 1, m_rdata, m_err, sel_seen,
                                 e.exp_edge, e.rdata, e.err, e.sel_cycles);
                    end
                    pend = 1;
                    pend_cnt = e.errcnt;
                end
                sel_seen = 0;
            end
        end
    end

    function automatic int find_slave(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if (a >= base_a[i] && a <= limit_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int k, input bit b2b, input bit keep);
        exp_t   e;
        int     idx;
        int     n;
        longint acc;
        bit     done;
        if (!b2b) begin
            n = 0;
            @(negedge clk);
            while (busy !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL idle_wait: busy=%b after 100 cycles, required 0", busy);
            end
            acc = cyc + 1;
        end else begin
            acc = cyc + 2;
        end
        idx = find_slave(addr);
        for (int i = 0; i < 5; i++) sl_rd[i] = $urandom;
        sl_idx = (idx < 0) ? 0 : idx;
        sl_k   = k;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.wstrb = wstrb;
        if (idx < 0) begin
            e.sel = 5'b0;
            e.sel_cycles = 0;
            e.err = 1'b1;
            e.rdata = 32'h0;
        end else begin
            done = (k >= 1 && k <= TO);
            e.sel = 5'b0;
            e.sel[idx] = 1'b1;
            e.sel_cycles = done ? k : TO;
            e.err = !done;
            e.rdata = (done && !we) ? sl_rd[idx] : 32'h0;
        end
        e.exp_edge = acc + ((idx < 0) ? 1 : e.sel_cycles + 1);
        if (e.err && model_errcnt < 255) model_errcnt++;
        e.errcnt = model_errcnt;
        q.push_back(e);
        m_valid = 1'b1;
        m_addr  = addr;
        m_we    = we;
        m_wdata = wdata;
        m_wstrb = wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_ready !== 1'b1 && n < 60);
        if (m_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_wait addr=%h: m_ready=%b after 60 cycles, required 1", addr, m_ready);
            q.delete();
        end
        if (!keep) m_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edge_addrs [10];
        bit          prev_keep;
        bit          keep;
        logic [31:0] a;
        int          s;

        edge_addrs = '{32'h3FFF, 32'h4000, 32'h6FFF, 32'h7000, 32'h7FFF,
                       32'h800F, 32'h8010, 32'h802F, 32'h8030, 32'hFFFF_FFFF};

        m_valid = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_ready !== 1'b0 || busy !== 1'b0 || s_sel !== 5'b0 || err_cnt !== 8'd0 ||
            m_rdata !== 32'h0 || m_err !== 1'b0 || s_addr !== 32'h0 || s_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b sel=%b err_cnt=%0d rdata=%h err=%b addr=%h we=%b, required all 0",
                     m_ready, busy, s_sel, err_cnt, m_rdata, m_err, s_addr, s_we);
        end
        rst = 1'b0;

        issue(32'h0000_4010, 1'b0, $urandom, 4'hF, 1, 0, 0);
        issue(32'h0000_8014, 1'b1, 32'hA5, 4'b0001, 3, 0, 0);
        issue(32'h0000_7000, 1'b0, $urandom, 4'hF, 1, 0, 0);
        issue(32'h0000_8030, 1'b0, $urandom, 4'hF, 1, 0, 0);
        issue(32'h0000_8000, 1'b0, $urandom, 4'hF, 0, 0, 0);
        issue(32'h0000_8008, 1'b0, $urandom, 4'hF, 16, 0, 0);
        issue(32'h0000_8004, 1'b0, $urandom, 4'hF, 17, 0, 0);
        foreach (edge_addrs[i]) issue(edge_addrs[i], 1'(i % 2), $urandom, 4'(i), 2, 0, 0);

        @(negedge clk);
        rst_test = 1;
        sl_idx = 2;
        sl_k = 0;
        m_valid = 1'b1; m_addr = 32'h0000_8004; m_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_sel !== 5'b0 || busy !== 1'b0 || err_cnt !== 8'd0 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_access: sel=%b busy=%b err_cnt=%0d ready=%b, required 0 0 0 0",
                     s_sel, busy, err_cnt, m_ready);
        end
        rst = 1'b0;
        rst_test = 0;
        model_errcnt = 0;

        issue(32'h0000_8024, 1'b1, $urandom, 4'b1100, 2, 0, 0);

        for (int i = 0; i < 6; i++)
            issue(32'(i * 32'h1100), 1'b0, $urandom, 4'hF, 1, i > 0, i < 5);

        prev_keep = 0;
        for (int i = 0; i < 150; i++) begin
            s = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = $urandom_range(0, 32'h9000);
                2: a = base_a[s] + $urandom_range(0, limit_a[s] - base_a[s]);
                default: a = ($urandom_range(0, 1) == 1) ? limit_a[s] + 1 : base_a[s];
            endcase
            keep = (i < 149) && ($urandom_range(0, 1) == 1);
            issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 20),
                  prev_keep, keep);
            prev_keep = keep;
        end

        for (int i = 0; i < 300; i++)
            issue(32'h0000_7000 + 32'(i * 4), 1'b0, $urandom, 4'hF, 1, i > 0, i < 299);

        issue(32'h0000_0100, 1'b0, $urandom, 4'hF, 1, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt !== 8'd255 || q.size() != 0) begin
            errors++;
            $display("FAIL err_cnt_saturate: err_cnt=%0d pending=%0d, required 255 and 0", err_cnt, q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_decode_arbiter.md
Name: bus_decode_arbiter

Overview:
- Parametrised, registered successor to the SoC address decoder: one master port fans out to NUM_SLAVES memory-mapped slaves.
- Slave windows are set by parameters (base/limit per slave), not hard-coded.
- Adds a request/ready handshake per slave, read-data return muxing, error responses for unmapped addresses, a per-access timeout and a saturating error counter.
- Sits between the core's load/store unit and the IMEM/DMEM/UART/GPIO/Timer slaves.

Parameters:
- NUM_SLAVES, 5, number of slave ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- SLAVE_BASE, {0x8020,0x8010,0x8000,0x4000,0x0000}, packed NUM_SLAVES*ADDR_W; slave i base at bits [i*ADDR_W +: ADDR_W].
- SLAVE_LIMIT, {0x802F,0x801F,0x800F,0x6FFF,0x3FFF}, packed; inclusive upper bound per slave.
- TIMEOUT, 16, maximum ACCESS cycles before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  1  master request; held high with stable fields until m_ready.
- m_addr  in  ADDR_W  request address.
- m_we  in  1  1 = write, 0 = read.
- m_wdata  in  DATA_W  write data.
- m_wstrb  in  STRB_W  byte enables.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  DATA_W  read data; valid while m_ready is high.
- m_err  out  1  error flag; valid while m_ready is high.
- s_sel  out  NUM_SLAVES  one-hot slave select, registered.
- s_addr  out  ADDR_W  latched address, shared by all slaves.
- s_we  out  1  latched write enable.
- s_wdata  out  DATA_W  latched write data.
- s_wstrb  out  STRB_W  latched byte enables.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_rdata  in  NUM_SLAVES*DATA_W  packed per-slave read data.
- busy  out  1  high whenever state is not IDLE.
- err_cnt  out  8  saturating count of error responses.

Behaviour:
- Reset: state = IDLE; all outputs and internal registers = 0.
- Decode:
  - Combinational on m_addr: hit[i] = (addr >= BASE[i]) && (addr <= LIMIT[i]), full-width unsigned compare.
  - On overlapping windows, the lowest index wins.
  - No hit = unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, with m_valid=1:
  - Latch addr, we, wdata, wstrb and the hit index.
  - On a hit: next state ACCESS, s_sel[idx] set, timeout counter cleared.
  - If unmapped: next state RESP with err=1, rdata=0, and no s_sel asserted.
- IDLE, with m_valid=0: stay in IDLE.
- ACCESS:
  - s_sel stays one-hot; s_addr, s_we, s_wdata and s_wstrb are held stable.
  - Only s_ready[idx] is sampled; other s_ready bits are ignored.
  - If s_ready[idx]=1:
    - Reads: capture s_rdata[idx] into m_rdata.
    - Writes: m_rdata = 0.
    - Set err=0, clear s_sel, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: clear s_sel, set err=1 and rdata=0, go to RESP.
  - Otherwise increment the counter.
  - s_sel is therefore high for at most TIMEOUT cycles.
  - s_ready on the final permitted cycle beats the timeout.
- RESP:
  - m_ready=1 for exactly one cycle, with m_rdata and m_err valid in that cycle.
  - Next state IDLE.
  - If err=1, err_cnt increments, saturating at 255.
  - m_rdata and m_err return to 0 in IDLE.
- Latency:
  - Slave ready in the first ACCESS cycle (k=1): m_ready two cycles after the IDLE acceptance edge.
  - General case: completion at ACCESS cycle k gives latency k+1.
  - Unmapped address: m_ready one cycle after acceptance.
- Back-to-back: the master may keep m_valid high after m_ready; the next request is accepted in the following IDLE cycle. Minimum spacing is 3 cycles.
- Reset mid-ACCESS: s_sel drops and the transaction is abandoned. No m_ready is issued, and err_cnt is cleared.
- m_valid dropping before m_ready is a protocol violation. The latched transaction still completes normally.

Test Plan:
- Read 0x0000_4010, DMEM returns s_ready[1] in the first ACCESS cycle with rdata 0xDEADBEEF -> s_sel=5'b00010 for 1 cycle; m_ready 2 cycles after acceptance; m_rdata=0xDEADBEEF; m_err=0.
- Write 0x0000_8014 (GPIO), wdata 0xA5, wstrb 4'b0001, ready after 3 ACCESS cycles -> s_sel=5'b01000 for 3 cycles with s_we=1, s_wdata=0xA5, s_wstrb=4'b0001; m_ready one cycle later; m_rdata=0; m_err=0.
- Unmapped reads at 0x0000_7000 and 0x0000_8030 -> s_sel never asserted; m_ready one cycle after each acceptance with m_err=1; err_cnt=2.
- UART never asserts ready, TIMEOUT=16 -> s_sel[2] high exactly 16 cycles; then m_ready with m_err=1 and m_rdata=0. Repeat with ready on the 16th cycle -> m_err=0.
- rst asserted during the 2nd ACCESS cycle -> next cycle s_sel=0, busy=0, err_cnt=0, no m_ready; a fresh request afterwards completes normally.
- 300 consecutive unmapped requests -> err_cnt saturates at 255; back-to-back m_valid gives m_ready every 3 cycles for mapped zero-wait slaves.
